// File: rtl/baw_turn_sequencer.sv
// baw_turn_sequencer: debounced button front end and round sequencer for the Black-and-White card game
module baw_turn_sequencer #(
    parameter logic [19:0] DB_CYCLES  = 20'd1_000_000,
    parameter int          MAX_ROUNDS = 9,
    parameter int          WIN_TARGET = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_commit,
    input  logic       btn_abort,
    input  logic [8:0] card_sel,
    input  logic [1:0] match_result,
    output logic [2:0] state,
    output logic       p1_commit,
    output logic       p2_commit,
    output logic [3:0] hand_idx,
    output logic [8:0] p1_used,
    output logic [8:0] p2_used,
    output logic       score_pulse,
    output logic [3:0] round,
    output logic [3:0] p1_wins,
    output logic [3:0] p2_wins,
    output logic       leader,
    output logic       sel_error,
    output logic       game_over,
    output logic [1:0] winner
);
    typedef enum logic [2:0] {
        IDLE = 3'd0, LEAD = 3'd1, FOLLOW = 3'd2, SETTLE = 3'd3,
        RESOLVE = 3'd4, SHOW = 3'd5, DONE = 3'd6
    } state_t;
    localparam logic [3:0] MAX_R = 4'(MAX_ROUNDS);
    localparam logic [3:0] WIN_T = 4'(WIN_TARGET);
    logic [2:0] raw, ev;
    assign raw = {btn_abort, btn_commit, btn_start};
    for (genvar b = 0; b < 3; b++) begin : g_db
        logic        s1_q, s2_q, lvl_q, lvl_p_q;
        logic [19:0] cnt_q;
        // two-flop synchronizer, then accept a new level after DB_CYCLES consecutive differing samples
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                s1_q    <= 1'b0;
                s2_q    <= 1'b0;
                lvl_q   <= 1'b0;
                lvl_p_q <= 1'b0;
                cnt_q   <= '0;
            end else begin
                s1_q    <= raw[b];
                s2_q    <= s1_q;
                lvl_p_q <= lvl_q;
                if (s2_q == lvl_q) cnt_q <= '0;
                else if (cnt_q == DB_CYCLES - 20'd1) begin
                    lvl_q <= s2_q;
                    cnt_q <= '0;
                end else cnt_q <= cnt_q + 20'd1;
            end
        end
        assign ev[b] = lvl_q & ~lvl_p_q;
    end
    logic start_ev, commit_ev, abort_ev;
    assign {abort_ev, commit_ev, start_ev} = ev;
    state_t     state_q, state_d;
    logic [8:0] sel1_q, sel_q, p1u_q, p1u_d, p2u_q, p2u_d;
    logic [3:0] round_q, round_d, p1w_q, p1w_d, p2w_q, p2w_d, hidx_q, hidx_d, idx;
    logic       leader_q, leader_d, err_q, err_d, p1c_q, p1c_d, p2c_q, p2c_d, score_q, score_d;
    logic       actor, sel_ok;
    // one-hot switch position to card value
    always_comb begin
        idx = 4'd0;
        for (int k = 0; k < 9; k++) if (sel_q[k]) idx = 4'(k);
    end
    // actor is the leader in LEAD and the other player in FOLLOW
    assign actor  = (state_q == FOLLOW) ^ leader_q;
    assign sel_ok = $onehot(sel_q) && ~|(sel_q & (actor ? p2u_q : p1u_q));
    // next-state and datapath updates; abort overrides every other event
    always_comb begin
        state_d  = state_q;
        p1u_d    = p1u_q;
        p2u_d    = p2u_q;
        round_d  = round_q;
        p1w_d    = p1w_q;
        p2w_d    = p2w_q;
        leader_d = leader_q;
        err_d    = err_q;
        hidx_d   = hidx_q;
        p1c_d    = 1'b0;
        p2c_d    = 1'b0;
        score_d  = 1'b0;
        if (abort_ev || ((state_q == IDLE || state_q == DONE) && start_ev)) begin
            state_d  = abort_ev ? IDLE : LEAD;
            p1u_d    = '0;
            p2u_d    = '0;
            round_d  = '0;
            p1w_d    = '0;
            p2w_d    = '0;
            leader_d = 1'b0;
            err_d    = 1'b0;
        end else begin
            case (state_q)
                LEAD, FOLLOW: if (commit_ev) begin
                    err_d = ~sel_ok;
                    if (sel_ok) begin
                        hidx_d  = idx;
                        state_d = (state_q == LEAD) ? FOLLOW : SETTLE;
                        p1u_d   = actor ? p1u_q : (p1u_q | sel_q);
                        p2u_d   = actor ? (p2u_q | sel_q) : p2u_q;
                        p1c_d   = ~actor;
                        p2c_d   = actor;
                    end
                end
                SETTLE:  state_d = RESOLVE;
                RESOLVE: begin
                    p1w_d    = p1w_q + {3'd0, match_result == 2'b01 && p1w_q != 4'hF};
                    p2w_d    = p2w_q + {3'd0, match_result == 2'b10 && p2w_q != 4'hF};
                    leader_d = (match_result == 2'b01) ? 1'b0 : (match_result == 2'b10) ? 1'b1 : leader_q;
                    round_d  = round_q + {3'd0, round_q != 4'hF};
                    score_d  = 1'b1;
                    state_d  = SHOW;
                end
                SHOW:    state_d = (p1w_q == WIN_T || p2w_q == WIN_T || round_q == MAX_R) ? DONE : LEAD;
                IDLE, DONE: state_d = state_q;
                default: state_d = IDLE;
            endcase
        end
    end
    // state, game registers and registered strobes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            sel1_q   <= '0;
            sel_q    <= '0;
            p1u_q    <= '0;
            p2u_q    <= '0;
            round_q  <= '0;
            p1w_q    <= '0;
            p2w_q    <= '0;
            hidx_q   <= '0;
            leader_q <= 1'b0;
            err_q    <= 1'b0;
            p1c_q    <= 1'b0;
            p2c_q    <= 1'b0;
            score_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel1_q   <= card_sel;
            sel_q    <= sel1_q;
            p1u_q    <= p1u_d;
            p2u_q    <= p2u_d;
            round_q  <= round_d;
            p1w_q    <= p1w_d;
            p2w_q    <= p2w_d;
            hidx_q   <= hidx_d;
            leader_q <= leader_d;
            err_q    <= err_d;
            p1c_q    <= p1c_d;
            p2c_q    <= p2c_d;
            score_q  <= score_d;
        end
    end
    assign state       = state_q;
    assign p1_commit   = p1c_q;
    assign p2_commit   = p2c_q;
    assign hand_idx    = hidx_q;
    assign p1_used     = p1u_q;
    assign p2_used     = p2u_q;
    assign score_pulse = score_q;
    assign round       = round_q;
    assign p1_wins     = p1w_q;
    assign p2_wins     = p2w_q;
    assign leader      = leader_q;
    assign sel_error   = err_q;
    assign game_over   = (state_q == DONE);
    assign winner      = !game_over ? 2'b00 : (p1w_q > p2w_q) ? 2'b01 : (p2w_q > p1w_q) ? 2'b10 : 2'b11;
endmodule

// File: tb/tb_baw_turn_sequencer.sv
// tb_baw_turn_sequencer: directed game scenarios with commit/score scoreboards
module tb_baw_turn_sequencer;
    logic       clk = 1'b0, reset = 1'b1;
    logic       btn_start = 1'b0, btn_commit = 1'b0, btn_abort = 1'b0;
    logic [8:0] card_sel = '0;
    logic [1:0] match_result = '0;
    logic [2:0] state;
    logic       p1_commit, p2_commit, score_pulse, leader, sel_error, game_over;
    logic [3:0] hand_idx, round, p1_wins, p2_wins;
    logic [8:0] p1_used, p2_used;
    logic [1:0] winner;
    baw_turn_sequencer #(.DB_CYCLES(20'd4), .MAX_ROUNDS(9), .WIN_TARGET(5)) dut (
        .clk(clk), .reset(reset), .btn_start(btn_start), .btn_commit(btn_commit),
        .btn_abort(btn_abort), .card_sel(card_sel), .match_result(match_result),
        .state(state), .p1_commit(p1_commit), .p2_commit(p2_commit), .hand_idx(hand_idx),
        .p1_used(p1_used), .p2_used(p2_used), .score_pulse(score_pulse), .round(round),
        .p1_wins(p1_wins), .p2_wins(p2_wins), .leader(leader), .sel_error(sel_error),
        .game_over(game_over), .winner(winner)
    );
    always #5 clk = ~clk;
    int          total = 0, bad = 0;
    logic [4:0]  cq[$];
    logic [12:0] sq[$];
    logic [8:0]  m_u1, m_u2;
    logic [3:0]  m_p1w, m_p2w, m_round;
    logic        m_lead;
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    function automatic logic [3:0] idx_of(input logic [8:0] s);
        idx_of = 4'd0;
        for (int k = 0; k < 9; k++) if (s[k]) idx_of = 4'(k);
    endfunction
    always @(negedge clk) begin
        if (p1_commit || p2_commit) begin
            if (cq.size() == 0) chk("stray_commit", {14'd0, p2_commit, p1_commit}, 16'd0);
            else begin
                logic [4:0] e;
                e = cq.pop_front();
                chk("commit", {10'd0, p2_commit, p1_commit, hand_idx}, {10'd0, e[4], ~e[4], e[3:0]});
            end
        end
        if (score_pulse) begin
            if (sq.size() == 0) chk("stray_score", {15'd0, score_pulse}, 16'd0);
            else chk("score", {3'd0, p1_wins, p2_wins, round, leader}, {3'd0, sq.pop_front()});
        end
    end
    task automatic model_clear();
        m_u1 = '0; m_u2 = '0; m_p1w = '0; m_p2w = '0; m_round = '0; m_lead = 1'b0;
    endtask
    task automatic set_btn(input int w, input logic v);
        if (w == 0) btn_start = v;
        else if (w == 1) btn_commit = v;
        else btn_abort = v;
    endtask
    task automatic press(input int w);
        @(negedge clk);
        set_btn(w, 1'b1);
        repeat (8) @(negedge clk);
        set_btn(w, 1'b0);
        repeat (8) @(negedge clk);
    endtask
    task automatic do_commit(input logic p, input logic [8:0] sel, input logic ok);
        card_sel = sel;
        if (ok) begin
            cq.push_back({p, idx_of(sel)});
            if (p) m_u2 = m_u2 | sel;
            else m_u1 = m_u1 | sel;
        end
        press(1);
        chk("sel_error", {15'd0, sel_error}, {15'd0, !ok});
        chk("p1_used", {7'd0, p1_used}, {7'd0, m_u1});
        chk("p2_used", {7'd0, p2_used}, {7'd0, m_u2});
    endtask
    task automatic new_game();
        press(0);
        model_clear();
        chk("start_state", {13'd0, state}, 16'd1);
        chk("start_clear", {p1_wins, p2_wins, round, 1'b0, leader, winner}, 16'd0);
        chk("start_masks", {7'd0, p1_used | p2_used}, 16'd0);
    endtask
    task automatic play_round(input int lc, input int fc, input logic [1:0] mr);
        logic       lp;
        logic [8:0] one;
        one = 9'd1;
        lp = m_lead;
        match_result = mr;
        do_commit(lp, one << lc, 1'b1);
        chk("after_lead", {13'd0, state}, 16'd2);
        if (mr == 2'b01) begin m_p1w++; m_lead = 1'b0; end
        else if (mr == 2'b10) begin m_p2w++; m_lead = 1'b1; end
        m_round++;
        sq.push_back({m_p1w, m_p2w, m_round, m_lead});
        do_commit(!lp, one << fc, 1'b1);
        chk("after_round", {13'd0, state},
            (m_p1w == 4'd5 || m_p2w == 4'd5 || m_round == 4'd9) ? 16'd6 : 16'd1);
    endtask
    initial begin
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_state", {13'd0, state}, 16'd0);
        chk("rst_counts", {p1_wins, p2_wins, round, 4'd0}, 16'd0);
        chk("rst_flags", {9'd0, p1_commit, p2_commit, score_pulse, leader, sel_error, game_over, 1'b0}, 16'd0);
        chk("rst_masks", {7'd0, p1_used | p2_used}, 16'd0);
        chk("rst_winner", {14'd0, winner}, 16'd0);
        @(negedge clk);
        btn_start = 1'b1;
        repeat (3) @(negedge clk);
        btn_start = 1'b0;
        repeat (10) @(negedge clk);
        chk("glitch_idle", {13'd0, state}, 16'd0);
        btn_start = 1'b1;
        repeat (6) @(posedge clk);
        #1 chk("db_edge6", {13'd0, state}, 16'd0);
        @(posedge clk);
        #1 chk("db_edge7", {13'd0, state}, 16'd1);
        repeat (6) @(negedge clk);
        btn_start = 1'b0;
        repeat (8) @(negedge clk);
        chk("db_once", {13'd0, state}, 16'd1);
        do_commit(1'b0, 9'h011, 1'b0);
        chk("inv_two_state", {13'd0, state}, 16'd1);
        do_commit(1'b0, 9'h000, 1'b0);
        chk("inv_zero_state", {13'd0, state}, 16'd1);
        play_round(4, 2, 2'b01);
        chk("r1_leader", {15'd0, leader}, 16'd0);
        do_commit(1'b0, 9'h010, 1'b0);
        chk("inv_reuse_state", {13'd0, state}, 16'd1);
        play_round(0, 0, 2'b10);
        chk("r2_leader", {15'd0, leader}, 16'd1);
        play_round(1, 1, 2'b00);
        chk("r3_tie_leader", {15'd0, leader}, 16'd1);
        play_round(3, 3, 2'b11);
        chk("r4_tie_leader", {15'd0, leader}, 16'd1);
        do_commit(1'b1, 9'h020, 1'b1);
        chk("abort_pre", {13'd0, state}, 16'd2);
        press(2);
        model_clear();
        chk("abort_state", {13'd0, state}, 16'd0);
        chk("abort_counts", {p1_wins, p2_wins, round, 3'd0, leader}, 16'd0);
        chk("abort_masks", {7'd0, p1_used | p2_used}, 16'd0);
        new_game();
        for (int r = 0; r < 5; r++) play_round(r, r, 2'b01);
        chk("p1_game_over", {15'd0, game_over}, 16'd1);
        chk("p1_winner", {14'd0, winner}, 16'd1);
        new_game();
        do_commit(1'b0, 9'h001, 1'b1);
        card_sel = 9'h001;
        match_result = 2'b01;
        cq.push_back({1'b1, 4'd0});
        btn_commit = 1'b1;
        for (int i = 0; i < 30 && state != 3'd3; i++) @(negedge clk);
        chk("reach_settle", {13'd0, state}, 16'd3);
        #1 reset = 1'b1;
        #1 chk("rst_mid_state", {13'd0, state}, 16'd0);
        chk("rst_mid_flags", {12'd0, p1_commit, p2_commit, score_pulse, sel_error}, 16'd0);
        chk("rst_mid_masks", {7'd0, p1_used | p2_used}, 16'd0);
        btn_commit = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_mid_idle", {13'd0, state}, 16'd0);
        new_game();
        play_round(0, 0, 2'b01);
        play_round(1, 1, 2'b10);
        play_round(2, 2, 2'b01);
        play_round(3, 3, 2'b10);
        play_round(4, 4, 2'b01);
        play_round(5, 5, 2'b10);
        play_round(6, 6, 2'b01);
        play_round(7, 7, 2'b10);
        play_round(8, 8, 2'b00);
        chk("draw_round", {12'd0, round}, 16'd9);
        chk("draw_game_over", {15'd0, game_over}, 16'd1);
        chk("draw_winner", {14'd0, winner}, 16'd3);
        repeat (5) @(negedge clk);
        chk("commit_queue_empty", 16'(cq.size()), 16'd0);
        chk("score_queue_empty", 16'(sq.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/baw_turn_sequencer.md
# baw_turn_sequencer

Game-flow controller for the Black-and-White card game datapath. It debounces the player buttons and sequences each round as leader turn, then follower turn, then resolve. It validates card selections against each player's spent-card mask, issues one-cycle commit and score strobes to the hand-card, card and score registers, and tracks round, wins and game end. It sits between the board I/O (buttons, switches) and the per-player datapath, and it supplies the `state` code consumed by the display logic.

## Interface
- `DB_CYCLES`, 20'd1_000_000: consecutive stable samples required before a button level is accepted.
- `MAX_ROUNDS`, 9: rounds per game (one per card value 0..8).
- `WIN_TARGET`, 5: wins that end the game early.
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `btn_start`, `btn_commit`, `btn_abort` in 1 each: raw, asynchronous buttons.
- `card_sel` in 9: raw switches; bit k selects card value k.
- `match_result` in 2: from the comparator. 00 tie, 01 P1 higher, 10 P2 higher, 11 treated as tie.
- `state` out 3: current FSM state code.
- `p1_commit`, `p2_commit` out 1: one-cycle strobes; datapath captures `hand_idx` and updates that player's registers.
- `hand_idx` out 4: committed card value 0..8; valid while a commit strobe is high.
- `p1_used`, `p2_used` out 9: spent-card masks.
- `score_pulse` out 1: one-cycle strobe after each resolve.
- `round` out 4: completed rounds.
- `p1_wins`, `p2_wins` out 4: win counts.
- `leader` out 1: 0 when P1 leads the current round, 1 when P2 leads.
- `sel_error` out 1: last commit attempt was invalid.
- `game_over` out 1: game has ended.
- `winner` out 2: 01 P1, 10 P2, 11 draw, 00 while the game is in progress.

## Operation
- Each button path: 2-FF synchronizer, then a counter that accepts a new level after `DB_CYCLES` equal samples, then rising-edge detection. The result is a one-cycle event per press.
- States: IDLE 000, LEAD 001, FOLLOW 010, SETTLE 011, RESOLVE 100, SHOW 101, DONE 110.
- Valid selection: `card_sel` (synchronized) has exactly one bit set, and that bit is clear in the acting player's used mask.
- IDLE: `start` clears masks, round, wins, `leader`, `sel_error` and `winner`, then goes to LEAD.
- LEAD: on a valid `commit`, set the leader's used bit, fire the leader's commit strobe and go to FOLLOW. On an invalid `commit`, set `sel_error` and stay.
- FOLLOW: same rules applied to the other player; go to SETTLE.
- SETTLE: one cycle for the datapath to register hands, then RESOLVE.
- RESOLVE (one cycle): sample `match_result`.
  - 01 increments `p1_wins` and sets `leader`=0.
  - 10 increments `p2_wins` and sets `leader`=1.
  - Tie leaves `leader` unchanged.
  - `round` increments. Go to SHOW.
- SHOW: `score_pulse` is high for the first cycle. The next edge goes to DONE if any win count equals `WIN_TARGET` or `round` equals `MAX_ROUNDS`, otherwise to LEAD.
- DONE: `game_over`=1 and `winner` is set by comparing win counts. `start` begins a new game, identical to the IDLE action.
- Any valid commit clears `sel_error`. `start` also clears it.
- `abort` in any state: go to IDLE, clear all counters and masks, suppress strobes. `abort` has priority over `start` and `commit` in the same cycle.
- `start` is ignored outside IDLE/DONE. `commit` is ignored outside LEAD/FOLLOW.
- Counters saturate at 4'd15; this is unreachable with legal parameters.

## Timing
- Reset values: state=IDLE; all strobes, masks, counts, `leader`, `sel_error`, `game_over` and `winner` = 0; debounced levels = 0.
- Button latency: a raw rise held stably before edge 1 yields the event in the cycle after edge `DB_CYCLES`+2. The state changes on edge `DB_CYCLES`+3.
- A commit strobe and `hand_idx` are high for exactly the first cycle of the successor state (FOLLOW or SETTLE).
- `match_result` is sampled on the edge leaving RESOLVE, two edges after the follower strobe.
- Wins, round and `leader` update on that same edge.
- Round cycle count excluding button latency: FOLLOW→SETTLE→RESOLVE→SHOW→LEAD is 4 edges.
- Reset asserted mid-round returns all outputs to reset values immediately, with no strobe glitch.

## Test plan
- Debounce (DB_CYCLES=4): 3-cycle glitch on `btn_start` leaves state at IDLE. A stable press moves to LEAD on edge 7, exactly once per press.
- Legal round: P1 commits `card_sel`=9'h010, P2 commits 9'h004, `match_result`=01. Required: `p1_commit`, `hand_idx`=4 and `p2_commit`, `hand_idx`=2 each for 1 cycle. Then `p1_wins`=1, `round`=1, `score_pulse` for 1 cycle, `leader`=0.
- Invalid selection: two bits set, zero bits set, or a reused card. Required: `sel_error`=1, state and masks unchanged, no strobe. A subsequent valid commit clears `sel_error`.
- Leader hand-off and tie: P2 wins round 1, so `leader`=1 and the P2 strobe comes first in round 2. A tie in round 2 keeps `leader`=1.
- Game end: P1 wins 5 rounds, giving DONE after round 5 with `winner`=01. A 9-round game with 4–4 wins plus 1 tie gives `winner`=11.
- Abort and reset: `btn_abort` pressed in FOLLOW, and `reset` asserted in SETTLE. Both give IDLE, zeroed masks and counts, and no `score_pulse`.
